// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised loadable up/down counter with wrap/saturate limits and terminal-count pulse
//
// Parameters:
//   WIDTH    counter and data width in bits (>=2)
//   MAX_VAL  highest count value, count range is 0..MAX_VAL
//   RST_VAL  value of out after reset
//   PRESCALE (only with PRESCALE_EN) enabled edges per count step
//
// Optional feature macro: PRESCALE_EN adds a prescaler so the counter steps
// only on every PRESCALE-th enabled edge.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   data      parallel load value, clamped to MAX_VAL
//   load      synchronous load strobe (highest priority)
//   enable    count enable
//   up_dn     direction: 1 = up, 0 = down
//   sat_mode  boundary mode: 1 = saturate, 0 = wrap
//   out       current count, registered
//   tc        terminal-count pulse, registered
//   zero      combinational, high when out == 0
module mod_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int RST_VAL = 0
`ifdef PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);
  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST = RST_VAL[WIDTH-1:0];
  logic             step;
  logic             at_top;
  logic             at_bot;
  logic             bound;
  logic [WIDTH-1:0] next;
`ifdef PRESCALE_EN
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre;
  assign step = enable && pre == PRE_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else if (load) pre <= '0;
    else if (enable) pre <= step ? '0 : pre + PW'(1);
`else
  assign step = enable;
`endif
  // >= so an out-of-range reset value is treated as the upper boundary
  always_comb begin
    at_top = out >= MAX;
    at_bot = out == '0;
    bound  = up_dn ? at_top : at_bot;
    next   = up_dn ? (at_top ? (sat_mode ? out : '0) : out + WIDTH'(1))
                   : (at_bot ? (sat_mode ? out : MAX) : out - WIDTH'(1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= RST;
      tc  <= 1'b0;
    end else if (load) begin
      out <= data > MAX ? MAX : data;
      tc  <= 1'b0;
    end else if (step) begin
      out <= next;
      tc  <= bound;
    end else
      tc <= 1'b0;
  assign zero = out == '0;
endmodule
